layer_sequencer: RTL and testbench

//  Parametrised multi-layer scheduler for the PB array. Accepts one input tensor
//  (NUM_PB tiles of MAT_ELEMS words each) and fetches per-layer weights/biases from
//  a 1-cycle-latency parameter store. It dispatches each layer to all PBs and

---
 rtl/layer_sequencer_if.sv | 49 ++++
 rtl/layer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Signal bundle between layer_sequencer and its environment: input/output tensor
// streams, parameter-store lookup and the PB array dispatch/collect lines.
interface layer_sequencer_if #(
  parameter int NUM_PB     = 16,
  parameter int MAT_ELEMS  = 16,
  parameter int DATA_W     = 32,
  parameter int NUM_LAYERS = 2
);
  localparam int LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TENS_W = NUM_PB * MAT_ELEMS * DATA_W;
  localparam int BIAS_W = NUM_PB * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [TENS_W-1:0] in_x;

  logic [LW-1:0]     prm_layer;
  logic [TENS_W-1:0] prm_w;
  logic [BIAS_W-1:0] prm_b;

  logic              pb_start;
  logic [TENS_W-1:0] pb_x;
  logic [TENS_W-1:0] pb_w;
  logic [BIAS_W-1:0] pb_b;
  logic [NUM_PB-1:0] pb_done;
  logic [TENS_W-1:0] pb_y;

  logic              out_valid;
  logic              out_ready;
  logic [TENS_W-1:0] out_x;

  logic              busy;
  logic [LW-1:0]     cur_layer;
  logic              err_timeout;

  // sequencer side
  modport master (
    input  in_valid, in_x, prm_w, prm_b, pb_done, pb_y, out_ready,
    output in_ready, prm_layer, pb_start, pb_x, pb_w, pb_b,
           out_valid, out_x, busy, cur_layer, err_timeout
  );

  // environment side: tensor source/sink, parameter store, PB array
  modport slave (
    output in_valid, in_x, prm_w, prm_b, pb_done, pb_y, out_ready,
    input  in_ready, prm_layer, pb_start, pb_x, pb_w, pb_b,
           out_valid, out_x, busy, cur_layer, err_timeout
  );
endinterface

// File: rtl/layer_sequencer.sv
// Clocked N-layer scheduler for the PB array: fetches per-layer parameters,
// dispatches each layer, gathers PB results and feeds them into the next layer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for an input tensor, in_ready high
// S_FETCH | layer index presented to the parameter store
// S_START | store data captured, pb_start pulsed, done mask/watchdog cleared
// S_WAIT  | collecting per-PB results until every tile reported or timeout
// S_OUT   | final tensor presented until downstream accepts
module layer_sequencer #(
  parameter int NUM_PB     = 16,
  parameter int MAT_ELEMS  = 16,
  parameter int DATA_W     = 32,
  parameter int NUM_LAYERS = 2,
  parameter int TIMEOUT    = 1024
) (
  input logic clk,
  input logic rst,
  layer_sequencer_if.master bus
);
  localparam int LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int TILE_W = MAT_ELEMS * DATA_W;
  localparam int TENS_W = NUM_PB * TILE_W;
  localparam int BIAS_W = NUM_PB * DATA_W;

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [TW-1:0] WD_LIMIT   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [TENS_W-1:0] x_reg;
  logic [TENS_W-1:0] w_reg;
  logic [BIAS_W-1:0] b_reg;
  logic [TENS_W-1:0] y_reg;
  logic [TENS_W-1:0] out_reg;
  logic [NUM_PB-1:0] mask;
  logic [LW-1:0]     layer;
  logic [TW-1:0]     wd;
  logic              err_q;

  logic [NUM_PB-1:0] capture;
  logic [NUM_PB-1:0] mask_nxt;
  logic [TENS_W-1:0] y_merged;
  logic              all_done;
  logic              wd_expired;
  logic              last_layer;

  // Same-cycle captures are merged so the layer can complete on the cycle the
  // final tile reports, without waiting for y_reg to settle.
  always_comb begin
    capture  = '0;
    y_merged = y_reg;
    if (state == S_WAIT) begin
      capture = bus.pb_done & ~mask;
    end
    for (int p = 0; p < NUM_PB; p++) begin
      if (capture[p]) begin
        y_merged[p*TILE_W +: TILE_W] = bus.pb_y[p*TILE_W +: TILE_W];
      end
    end
    mask_nxt   = mask | capture;
    all_done   = &mask_nxt;
    wd_expired = !all_done && (wd == WD_LIMIT);
    last_layer = (layer == LAST_LAYER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (all_done) begin
          state_nxt = last_layer ? S_OUT : S_FETCH;
        end else if (wd_expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.pb_start  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      S_START: bus.pb_start  = 1'b1;
      S_OUT:   bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg   <= '0;
      w_reg   <= '0;
      b_reg   <= '0;
      y_reg   <= '0;
      out_reg <= '0;
      mask    <= '0;
      layer   <= '0;
      wd      <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.in_x;
            layer <= '0;
          end
        end
        S_START: begin
          w_reg <= bus.prm_w;
          b_reg <= bus.prm_b;
          mask  <= '0;
          wd    <= '0;
        end
        S_WAIT: begin
          y_reg <= y_merged;
          mask  <= mask_nxt;
          if (all_done) begin
            x_reg <= y_merged;
            if (last_layer) begin
              out_reg <= y_merged;
            end else begin
              layer <= layer + LW'(1);
            end
          end else if (wd_expired) begin
            // abort drops the partial result; the index returns to 0 for the next job
            err_q <= 1'b1;
            layer <= '0;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) layer <= '0;
        end
        default: ;
      endcase
    end
  end

  // layer doubles as the store address; it is stable through FETCH and START
  assign bus.prm_layer   = layer;
  assign bus.cur_layer   = layer;
  assign bus.pb_x        = x_reg;
  assign bus.pb_w        = w_reg;
  assign bus.pb_b        = b_reg;
  assign bus.out_x       = out_reg;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: three instances cover the default 16-PB
// two-layer engine, a short-watchdog abort, and a four-layer parameter sweep.
module tb_layer_sequencer;
  localparam int A_PB = 16, A_ME = 16, A_NL = 2;
  localparam int A_TN = A_PB * A_ME * 32;
  localparam int B_PB = 8, B_ME = 2, B_NL = 1, B_TO = 16;
  localparam int B_TN = B_PB * B_ME * 32;
  localparam int C_PB = 4, C_ME = 2, C_NL = 4;
  localparam int C_TN = C_PB * C_ME * 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  layer_sequencer_if #(.NUM_PB(A_PB), .MAT_ELEMS(A_ME), .DATA_W(32), .NUM_LAYERS(A_NL)) ifa ();
  layer_sequencer_if #(.NUM_PB(B_PB), .MAT_ELEMS(B_ME), .DATA_W(32), .NUM_LAYERS(B_NL)) ifb ();
  layer_sequencer_if #(.NUM_PB(C_PB), .MAT_ELEMS(C_ME), .DATA_W(32), .NUM_LAYERS(C_NL)) ifc ();

  layer_sequencer #(.NUM_PB(A_PB), .MAT_ELEMS(A_ME), .DATA_W(32), .NUM_LAYERS(A_NL),
                    .TIMEOUT(1024)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  layer_sequencer #(.NUM_PB(B_PB), .MAT_ELEMS(B_ME), .DATA_W(32), .NUM_LAYERS(B_NL),
                    .TIMEOUT(B_TO)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  layer_sequencer #(.NUM_PB(C_PB), .MAT_ELEMS(C_ME), .DATA_W(32), .NUM_LAYERS(C_NL),
                    .TIMEOUT(1024)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // PB array models: since_* is 1 in the first WAIT cycle after a pb_start.
  int   d_a [A_PB];
  int   h_a [A_PB];
  int   since_a = 0, since_b = 0, since_c = 0;
  logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
  logic [1:0] lat_c = 2'd0;
  int   sl_a [$];

  always @(negedge clk) begin
    st_a  <= ifa.pb_start;
    st_b  <= ifb.pb_start;
    st_c  <= ifc.pb_start;
    lat_c <= ifc.prm_layer;
    if (ifa.pb_start === 1'b1) sl_a.push_back(int'(ifa.cur_layer));
  end

  always @(posedge clk) begin
    if (st_a) since_a <= 1; else if (since_a != 0 && since_a < 1000) since_a <= since_a + 1;
    if (st_b) since_b <= 1; else if (since_b != 0 && since_b < 1000) since_b <= since_b + 1;
    if (st_c) since_c <= 1; else if (since_c != 0 && since_c < 1000) since_c <= since_c + 1;
    ifc.prm_w <= store_w_c(lat_c);
    ifc.prm_b <= store_b_c(lat_c);
  end

  // PB0 result drifts by +100 after its first done cycle; only the first value may be kept.
  always_comb begin
    ifa.pb_done = '0;
    ifa.pb_y    = '0;
    for (int p = 0; p < A_PB; p++) begin
      ifa.pb_done[p] = (since_a >= d_a[p]) && (since_a < d_a[p] + h_a[p]);
      for (int e = 0; e < A_ME; e++) begin
        ifa.pb_y[(p*A_ME+e)*32 +: 32] = ifa.pb_x[(p*A_ME+e)*32 +: 32] + 32'd1 +
                                        ((p == 0 && since_a > d_a[0]) ? 32'd100 : 32'd0);
      end
    end
  end

  always_comb begin
    ifb.pb_done = '0;
    ifb.pb_y    = '0;
    for (int p = 0; p < B_PB; p++) begin
      ifb.pb_done[p] = (p != 7) && (since_b >= 3);
    end
    for (int i = 0; i < B_TN / 32; i++) ifb.pb_y[i*32 +: 32] = ifb.pb_x[i*32 +: 32] + 32'd1;
  end

  always_comb begin
    ifc.pb_done = (since_c == 2) ? '1 : '0;
    ifc.pb_y    = '0;
    for (int i = 0; i < C_TN / 32; i++) ifc.pb_y[i*32 +: 32] = ifc.pb_x[i*32 +: 32] + 32'd1;
  end

  assign ifa.prm_w = '1;
  assign ifa.prm_b = '1;
  assign ifb.prm_w = '0;
  assign ifb.prm_b = '0;

  function automatic logic [C_TN-1:0] store_w_c(logic [1:0] l);
    logic [C_TN-1:0] r;
    for (int p = 0; p < C_PB; p++)
      for (int e = 0; e < C_ME; e++)
        r[(p*C_ME+e)*32 +: 32] = {8'hA0, 6'd0, l, 8'(p), 8'(e)};
    return r;
  endfunction

  function automatic logic [C_PB*32-1:0] store_b_c(logic [1:0] l);
    logic [C_PB*32-1:0] r;
    for (int p = 0; p < C_PB; p++) r[p*32 +: 32] = {8'hB0, 6'd0, l, 8'(p), 8'h00};
    return r;
  endfunction

  function automatic logic [A_TN-1:0] fill_a(logic [31:0] v);
    logic [A_TN-1:0] r;
    for (int i = 0; i < A_TN / 32; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [B_TN-1:0] fill_b(logic [31:0] v);
    logic [B_TN-1:0] r;
    for (int i = 0; i < B_TN / 32; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pb_a(int dly, int hold);
    for (int p = 0; p < A_PB; p++) begin
      d_a[p] = dly;
      h_a[p] = hold;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) tick();
    tests++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", ifa.busy); end
    tests++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", ifa.in_ready); end
    tests++; if (ifa.out_valid !== 1'b0 || ifa.pb_start !== 1'b0 || ifa.err_timeout !== 1'b0) begin
      fails++; $display("FAIL rst_flags got ov=%b st=%b err=%b exp 0", ifa.out_valid, ifa.pb_start, ifa.err_timeout);
    end
    tests++; if (ifa.out_x[63:0] !== 64'd0 || ifc.prm_layer !== 2'd0) begin
      fails++; $display("FAIL rst_regs got out_x=%h prm_layer=%0d exp 0", ifa.out_x[63:0], ifc.prm_layer);
    end
    rst = 1'b0;
    tick();
    set_pb_a(3, 1);
    ifa.in_x = fill_a(32'd5);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    repeat (2) tick();
    tests++; if (ifa.pb_w !== fill_a(32'hFFFF_FFFF) || ifa.busy !== 1'b1) begin
      fails++; $display("FAIL mid_wait got pb_w=%h busy=%b exp ffffffffffffffff 1", ifa.pb_w[63:0], ifa.busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (ifa.busy !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.pb_start !== 1'b0) begin
      fails++; $display("FAIL async_rst_ctrl got busy=%b rdy=%b st=%b exp 0 1 0", ifa.busy, ifa.in_ready, ifa.pb_start);
    end
    tests++; if (ifa.pb_x !== '0 || ifa.pb_w !== '0 || ifa.pb_b !== '0) begin
      fails++; $display("FAIL async_rst_data got pb_x=%h pb_w=%h exp 0", ifa.pb_x[63:0], ifa.pb_w[63:0]);
    end
    tests++; if (ifa.cur_layer !== 1'b0 || ifa.prm_layer !== 1'b0 || ifa.out_valid !== 1'b0) begin
      fails++; $display("FAIL async_rst_layer got cur=%b prm=%b ov=%b exp 0", ifa.cur_layer, ifa.prm_layer, ifa.out_valid);
    end
    #3 rst = 1'b0;
    sl_a.delete();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.busy === 1'b1) n++;
    end
    tests++; if (sl_a.size() != 0 || n != 0) begin
      fails++; $display("FAIL post_rst_quiet got starts=%0d busy_cycles=%0d exp 0 0", sl_a.size(), n);
    end
  endtask

  task automatic test_basic();
    int cyc;
    set_pb_a(3, 1);
    sl_a.delete();
    ifa.in_x = fill_a(32'd5);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    cyc = 1;
    while (ifa.out_valid !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    tests++; if (cyc != 11) begin fails++; $display("FAIL basic_latency got %0d exp 11", cyc); end
    tests++; if (ifa.out_x !== fill_a(32'd7)) begin
      fails++; $display("FAIL basic_out_x got %h exp 0000000700000007", ifa.out_x[63:0]);
    end
    tests++; if (sl_a.size() != 2) begin fails++; $display("FAIL basic_starts got %0d exp 2", sl_a.size()); end
    tests++; if (sl_a.size() != 2 || sl_a[0] != 0 || sl_a[1] != 1) begin
      fails++; $display("FAIL basic_layers got n=%0d first=%0d exp 0,1", sl_a.size(), (sl_a.size() > 0) ? sl_a[0] : -1);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    tests++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_accept got rdy=%b ov=%b exp 1 0", ifa.in_ready, ifa.out_valid);
    end
  endtask

  task automatic test_staggered();
    int cyc;
    for (int p = 0; p < A_PB; p++) begin d_a[p] = p + 1; h_a[p] = 1; end
    h_a[0] = 20;
    ifa.in_x = fill_a(32'd1);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    cyc = 1;
    while (!(ifa.pb_done[15] === 1'b1 && ifa.cur_layer === 1'b0) && cyc < 60) begin tick(); cyc++; end
    tests++; if (cyc != 18) begin fails++; $display("FAIL stag_pb15_cycle got %0d exp 18", cyc); end
    tick(); cyc++;
    tests++; if (ifa.cur_layer !== 1'b1 || ifa.prm_layer !== 1'b1) begin
      fails++; $display("FAIL stag_advance got cur=%b prm=%b exp 1 1", ifa.cur_layer, ifa.prm_layer);
    end
    while (ifa.out_valid !== 1'b1 && cyc < 80) begin tick(); cyc++; end
    tests++; if (cyc != 37) begin fails++; $display("FAIL stag_latency got %0d exp 37", cyc); end
    tests++; if (ifa.out_x !== fill_a(32'd3)) begin
      fails++; $display("FAIL stag_out_x got %h exp 0000000300000003", ifa.out_x[63:0]);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad_ov, bad_x, bad_rdy;
    set_pb_a(3, 1);
    ifa.in_x = fill_a(32'd9);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    cyc = 1;
    while (ifa.out_valid !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    tests++; if (cyc != 11) begin fails++; $display("FAIL bp_latency got %0d exp 11", cyc); end
    bad_ov = 0; bad_x = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_x = fill_a(32'd2);
      if (ifa.out_valid !== 1'b1) bad_ov++;
      if (ifa.out_x !== fill_a(32'd11)) bad_x++;
      if (ifa.in_ready !== 1'b0) bad_rdy++;
      tick();
    end
    ifa.in_valid = 1'b0;
    tests++; if (bad_ov != 0) begin fails++; $display("FAIL bp_out_valid got %0d drops exp 0", bad_ov); end
    tests++; if (bad_x != 0) begin fails++; $display("FAIL bp_out_x got %0d changes exp 0", bad_x); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL bp_in_ready got %0d high exp 0", bad_rdy); end
    tests++; if (ifa.out_valid !== 1'b1 || ifa.out_x !== fill_a(32'd11)) begin
      fails++; $display("FAIL bp_hold got ov=%b x=%h exp 1 0000000b0000000b", ifa.out_valid, ifa.out_x[63:0]);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    tests++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin
      fails++; $display("FAIL bp_release got rdy=%b ov=%b busy=%b exp 1 0 0", ifa.in_ready, ifa.out_valid, ifa.busy);
    end
    tick();
    tests++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL bp_stay_idle got busy=%b exp 0", ifa.busy); end
  endtask

  task automatic test_timeout();
    int cyc;
    int seen_ov;
    ifb.in_x = fill_b(32'd4);
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    cyc = 1;
    seen_ov = 0;
    while (ifb.err_timeout !== 1'b1 && cyc < 60) begin
      tick(); cyc++;
      if (ifb.out_valid === 1'b1) seen_ov++;
    end
    tests++; if (cyc != 19) begin fails++; $display("FAIL to_err_cycle got %0d exp 19", cyc); end
    tests++; if (ifb.busy !== 1'b0 || ifb.in_ready !== 1'b1) begin
      fails++; $display("FAIL to_idle got busy=%b rdy=%b exp 0 1", ifb.busy, ifb.in_ready);
    end
    tick();
    tests++; if (ifb.err_timeout !== 1'b0 || seen_ov != 0 || ifb.out_valid !== 1'b0) begin
      fails++; $display("FAIL to_pulse got err=%b ov_cycles=%0d exp 0 0", ifb.err_timeout, seen_ov);
    end
  endtask

  task automatic test_layers();
    int cyc, n, bad_w;
    int pl [$];
    logic [C_TN-1:0] x_in, x_exp;
    for (int i = 0; i < C_TN / 32; i++) begin
      x_in[i*32 +: 32]  = 32'(i * 16);
      x_exp[i*32 +: 32] = 32'(i * 16 + 4);
    end
    ifc.in_x = x_in;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    cyc = 1; n = 0; bad_w = 0;
    while (ifc.out_valid !== 1'b1 && cyc < 100) begin
      if (n > 0 && ifc.pb_start !== 1'b1 && cyc == 4 * n) begin
        if (ifc.pb_w !== store_w_c(2'(n - 1)) || ifc.pb_b !== store_b_c(2'(n - 1))) begin
          bad_w++;
          $display("FAIL lay_pb_w layer %0d got %h exp %h", n - 1, ifc.pb_w, store_w_c(2'(n - 1)));
        end
      end
      if (ifc.pb_start === 1'b1) begin pl.push_back(int'(ifc.prm_layer)); n++; end
      tick(); cyc++;
    end
    tests++; if (bad_w != 0) fails++;
    tests++; if (cyc != 17) begin fails++; $display("FAIL lay_latency got %0d exp 17", cyc); end
    tests++; if (pl.size() != 4) begin fails++; $display("FAIL lay_starts got %0d exp 4", pl.size()); end
    for (int i = 0; i < pl.size(); i++) begin
      tests++; if (pl[i] != i) begin fails++; $display("FAIL lay_prm_layer idx %0d got %0d exp %0d", i, pl[i], i); end
    end
    tests++; if (ifc.out_x !== x_exp) begin fails++; $display("FAIL lay_out_x got %h exp %h", ifc.out_x, x_exp); end
    tick();
    tests++; if (ifc.busy !== 1'b0 || ifc.cur_layer !== 2'd0) begin
      fails++; $display("FAIL lay_idle got busy=%b cur=%0d exp 0 0", ifc.busy, ifc.cur_layer);
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_x = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_x = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_x = '0; ifc.out_ready = 1'b1;
    set_pb_a(0, 0);
    test_reset();
    test_basic();
    test_staggered();
    test_backpressure();
    test_timeout();
    test_layers();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish exp finish before 100000");
    $fatal(1, "bench time limit");
  end
endmodule
